regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every register and data port.
- REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2^ADDR_WIDTH.
- REQ-003 SHALL have parameters TAP0, TAP1, TAP2, TAP3, defaults 1, 2, 4, 7, register indices exported on tap outputs.
- REQ-004 SHALL have ports:
  - clock  in  1  sole clock, rising edge.
  - ctrl_reset  in  1  synchronous, active-high reset.
  - ctrl_writeEnable  in  1  write enable, port A (processor).
  - ctrl_writeReg  in  ADDR_WIDTH  write index, port A.
  - data_writeReg  in  DATA_WIDTH  write data, port A.
  - ctrl_writeEnableB  in  1  write enable, port B (peripheral/game logic).
  - ctrl_writeRegB  in  ADDR_WIDTH  write index, port B.
  - data_writeRegB  in  DATA_WIDTH  write data, port B.
  - ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read indices.
  - data_readRegA, data_readRegB  out  DATA_WIDTH  read data.
  - tap0..tap3  out  DATA_WIDTH  live contents of registers TAP0..TAP3.
  - tap_upd  out  4  per-tap one-cycle pulse, set after an accepted write to that tap.
  - wr_collision  out  1  one-cycle pulse, set after a port-B write was dropped.
- REQ-005 SHALL use one clock; reset is synchronous and active-high.

Function
- REQ-006 Register 0 SHALL read as zero always; writes to index 0 on either port SHALL be ignored and SHALL NOT raise tap_upd or wr_collision.
- REQ-007 Writes SHALL take effect on the rising clock edge where enable is high; new value visible on reads and taps in the following cycle.
- REQ-008 Read ports SHALL be combinational from the register array (zero-cycle latency), subject to REQ-017.
- REQ-009 Both ports enabled with different non-zero indices: both writes SHALL commit on the same edge.
- REQ-010 Both ports enabled with the same non-zero index: port A data SHALL commit, port B write SHALL be dropped, wr_collision SHALL be 1 in the next cycle only.
- REQ-011 tap_upd[k] SHALL be 1 for exactly the cycle after an edge committing a write to index TAPk, else 0; consecutive writes SHALL give consecutive pulses.
- REQ-012 A dropped port-B write SHALL NOT raise tap_upd; the port-A write at the same index SHALL.
- REQ-013 A write committing the value already held SHALL still raise tap_upd.
- REQ-014 Two taps configured to the same index SHALL both pulse on a write to it.
- REQ-015 Indices SHALL never be out of range (depth is a full power of two); no wrap logic.

Reset
- REQ-016 On a rising edge with ctrl_reset high, all registers, tap_upd and wr_collision SHALL clear to 0; concurrent writes on either port SHALL be discarded; reads, taps and status SHALL show 0 in the next cycle.

Configuration
- REQ-017 Macro REGFILE_BYPASS_EN: defined -> a read whose index equals a write index committing this cycle SHALL return the committing data combinationally (port A priority per REQ-010; index 0 still returns 0; no bypass while ctrl_reset is high); undefined -> reads SHALL return the pre-edge stored value.

Verification
- REQ-018 Reset, then write 0xDEADBEEF to r5 via port A -> next cycle data_readRegA(r5)=0xDEADBEEF, tap_upd=0.
- REQ-019 Port A writes 0x11 to r3, port B writes 0x22 to r3 same edge -> r3=0x11, wr_collision=1 for one cycle, tap_upd=0.
- REQ-020 Port B writes 0x0A to r4 (TAP2) -> tap2=0x0A, tap_upd=4'b0100 for one cycle; port A simultaneously writes 0x7 to r1 -> tap0=0x7, tap_upd=4'b0101.
- REQ-021 Write 0xFFFF to r0 on both ports -> r0 reads 0, wr_collision=0, tap_upd=0.
- REQ-022 Write 0x55 to r7, read r7 same cycle -> 0x55 with REGFILE_BYPASS_EN, previous value without.
- REQ-023 Registers loaded, ctrl_reset high with port A writing 0x99 to r2 -> next cycle all reads and taps 0, tap_upd=0.

Source files
------------

// File: rtl/regfile_param.sv
// Dual-write-port register file with two combinational read ports, four tap outputs and write-status pulses.
// Optional REGFILE_BYPASS_EN: reads forward the data being committed this cycle.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TAP0       = 1,
    parameter int TAP1       = 2,
    parameter int TAP2       = 4,
    parameter int TAP3       = 7
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_writeEnableB,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeRegB,
    input  logic [DATA_WIDTH-1:0] data_writeRegB,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic [DATA_WIDTH-1:0] tap0,
    output logic [DATA_WIDTH-1:0] tap1,
    output logic [DATA_WIDTH-1:0] tap2,
    output logic [DATA_WIDTH-1:0] tap3,
    output logic [3:0]            tap_upd,
    output logic                  wr_collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH-1:0] idx_t;

    localparam idx_t TAP0_IDX = idx_t'(TAP0);
    localparam idx_t TAP1_IDX = idx_t'(TAP1);
    localparam idx_t TAP2_IDX = idx_t'(TAP2);
    localparam idx_t TAP3_IDX = idx_t'(TAP3);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [3:0]            tap_upd_q, tap_upd_d;
    logic                  coll_q, coll_d;
    logic                  wr_a_ok, wr_b_req, wr_b_ok;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;

    function automatic logic tap_hit(input logic a_ok, input idx_t a_idx,
                                     input logic b_ok, input idx_t b_idx,
                                     input idx_t tap_idx);
        return (a_ok && (a_idx == tap_idx)) || (b_ok && (b_idx == tap_idx));
    endfunction

    // Index 0 is hard-wired to zero, so writes to it never count as accepted.
    always_comb begin
        wr_a_ok      = ctrl_writeEnable && (ctrl_writeReg != '0);
        wr_b_req     = ctrl_writeEnableB && (ctrl_writeRegB != '0);
        coll_d       = wr_b_req && wr_a_ok && (ctrl_writeRegB == ctrl_writeReg);
        wr_b_ok      = wr_b_req && !coll_d;
        tap_upd_d    = '0;
        tap_upd_d[0] = tap_hit(wr_a_ok, ctrl_writeReg, wr_b_ok, ctrl_writeRegB, TAP0_IDX);
        tap_upd_d[1] = tap_hit(wr_a_ok, ctrl_writeReg, wr_b_ok, ctrl_writeRegB, TAP1_IDX);
        tap_upd_d[2] = tap_hit(wr_a_ok, ctrl_writeReg, wr_b_ok, ctrl_writeRegB, TAP2_IDX);
        tap_upd_d[3] = tap_hit(wr_a_ok, ctrl_writeReg, wr_b_ok, ctrl_writeRegB, TAP3_IDX);
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            tap_upd_q <= '0;
            coll_q    <= 1'b0;
        end else begin
            if (wr_b_ok) begin
                regs_q[ctrl_writeRegB] <= data_writeRegB;
            end
            if (wr_a_ok) begin
                regs_q[ctrl_writeReg] <= data_writeReg;
            end
            tap_upd_q <= tap_upd_d;
            coll_q    <= coll_d;
        end
    end

    // Port A is applied last so it wins when both ports target the read index.
    always_comb begin
        rd_a = regs_q[ctrl_readRegA];
        rd_b = regs_q[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (!ctrl_reset) begin
            if (wr_b_ok && (ctrl_writeRegB == ctrl_readRegA)) rd_a = data_writeRegB;
            if (wr_a_ok && (ctrl_writeReg == ctrl_readRegA))  rd_a = data_writeReg;
            if (wr_b_ok && (ctrl_writeRegB == ctrl_readRegB)) rd_b = data_writeRegB;
            if (wr_a_ok && (ctrl_writeReg == ctrl_readRegB))  rd_b = data_writeReg;
        end
`endif
        if (ctrl_readRegA == '0) rd_a = '0;
        if (ctrl_readRegB == '0) rd_b = '0;
    end

    assign data_readRegA = rd_a;
    assign data_readRegB = rd_b;
    assign tap0          = (TAP0_IDX == '0) ? '0 : regs_q[TAP0_IDX];
    assign tap1          = (TAP1_IDX == '0) ? '0 : regs_q[TAP1_IDX];
    assign tap2          = (TAP2_IDX == '0) ? '0 : regs_q[TAP2_IDX];
    assign tap3          = (TAP3_IDX == '0) ? '0 : regs_q[TAP3_IDX];
    assign tap_upd       = tap_upd_q;
    assign wr_collision  = coll_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: directed scenarios followed by random traffic against an array model.
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NREG = 1 << AW;
    localparam int TAPS [4] = '{1, 2, 4, 7};

    logic          clock;
    logic          ctrl_reset;
    logic          ctrl_writeEnable, ctrl_writeEnableB;
    logic [AW-1:0] ctrl_writeReg, ctrl_writeRegB, ctrl_readRegA, ctrl_readRegB;
    logic [DW-1:0] data_writeReg, data_writeRegB;
    logic [DW-1:0] data_readRegA, data_readRegB, tap0, tap1, tap2, tap3;
    logic [3:0]    tap_upd;
    logic          wr_collision;

    regfile_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .TAP0(TAPS[0]), .TAP1(TAPS[1]), .TAP2(TAPS[2]), .TAP3(TAPS[3])
    ) dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_writeEnableB(ctrl_writeEnableB), .ctrl_writeRegB(ctrl_writeRegB), .data_writeRegB(data_writeRegB),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .tap_upd(tap_upd), .wr_collision(wr_collision)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string         tag;
        logic [DW-1:0] rd_a, rd_b;
        logic [DW-1:0] tp [4];
        logic [3:0]    upd;
        logic          coll;
    } exp_t;

    exp_t          sb_q [$];
    int            n_cmp = 0;
    int            n_bad = 0;

    // Reference state: plain register array plus the status pulses the last edge produced.
    logic [DW-1:0] mem [NREG];
    logic [3:0]    m_upd;
    logic          m_coll;

    function automatic logic [DW-1:0] model_read(input int idx, input logic rst,
                                                 input logic wa, input int ia, input logic [DW-1:0] da,
                                                 input logic wb, input int ib, input logic [DW-1:0] db);
        if (idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!rst) begin
            if (wa && ia == idx) return da;
            if (wb && ib == idx) return db;
        end
`endif
        return mem[idx];
    endfunction

    task automatic chk(input string tag, input string what, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s/%s: got %h expected %h", tag, what, act, expv);
        end
    endtask

    task automatic drive(input string tag, input bit chk_en, input logic rst,
                         input logic wa, input int ia, input logic [DW-1:0] da,
                         input logic wb, input int ib, input logic [DW-1:0] db,
                         input int ra, input int rb);
        exp_t e;
        bit   drop_b;
        @(posedge clock);
        #2;
        ctrl_reset        = rst;
        ctrl_writeEnable  = wa;
        ctrl_writeReg     = AW'(ia);
        data_writeReg     = da;
        ctrl_writeEnableB = wb;
        ctrl_writeRegB    = AW'(ib);
        data_writeRegB    = db;
        ctrl_readRegA     = AW'(ra);
        ctrl_readRegB     = AW'(rb);
        if (chk_en) begin
            e.tag  = tag;
            e.rd_a = model_read(ra, rst, wa, ia, da, wb, ib, db);
            e.rd_b = model_read(rb, rst, wa, ia, da, wb, ib, db);
            for (int k = 0; k < 4; k++) e.tp[k] = mem[TAPS[k]];
            e.upd  = m_upd;
            e.coll = m_coll;
            sb_q.push_back(e);
        end
        // Advance the model across the coming edge.
        m_upd  = '0;
        m_coll = 1'b0;
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] = '0;
        end else begin
            drop_b = wa && wb && ia != 0 && ia == ib;
            m_coll = drop_b;
            if (wb && ib != 0 && !drop_b) begin
                mem[ib] = db;
                for (int k = 0; k < 4; k++) if (TAPS[k] == ib) m_upd[k] = 1'b1;
            end
            if (wa && ia != 0) begin
                mem[ia] = da;
                for (int k = 0; k < 4; k++) if (TAPS[k] == ia) m_upd[k] = 1'b1;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.tag, "rdA", data_readRegA, e.rd_a);
                chk(e.tag, "rdB", data_readRegB, e.rd_b);
                chk(e.tag, "tap0", tap0, e.tp[0]);
                chk(e.tag, "tap1", tap1, e.tp[1]);
                chk(e.tag, "tap2", tap2, e.tp[2]);
                chk(e.tag, "tap3", tap3, e.tp[3]);
                chk(e.tag, "tap_upd", DW'(tap_upd), DW'(e.upd));
                chk(e.tag, "wr_collision", DW'(wr_collision), DW'(e.coll));
            end
        end
    end

    initial begin : stimulus
        int ia, ib, ra, rb, waits;
        logic wa, wb, rst;
        logic [DW-1:0] da, db;
        ctrl_reset = 1'b1; ctrl_writeEnable = 1'b0; ctrl_writeEnableB = 1'b0;
        ctrl_writeReg = '0; ctrl_writeRegB = '0; data_writeReg = '0; data_writeRegB = '0;
        ctrl_readRegA = '0; ctrl_readRegB = '0;
        m_upd = '0; m_coll = 1'b0;
        for (int i = 0; i < NREG; i++) mem[i] = '0;

        drive("reset",      0, 1, 0, 0, 0,            0, 0, 0,         0, 0);
        drive("post_reset", 1, 0, 0, 0, 0,            0, 0, 0,         5, 0);
        drive("wr_r5",      1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,         5, 0);
        drive("rd_r5",      1, 0, 0, 0, 0,            0, 0, 0,         5, 1);
        drive("coll_r3",    1, 0, 1, 3, 32'h11,       1, 3, 32'h22,    3, 5);
        drive("rd_r3",      1, 0, 0, 0, 0,            0, 0, 0,         3, 4);
        drive("coll_clr",   1, 0, 0, 0, 0,            0, 0, 0,         3, 1);
        drive("b_tap2",     1, 0, 0, 0, 0,            1, 4, 32'h0A,    4, 1);
        drive("ab_taps",    1, 0, 1, 1, 32'h7,        1, 4, 32'h0A,    4, 1);
        drive("tap_pulse",  1, 0, 0, 0, 0,            0, 0, 0,         4, 1);
        drive("wr_r0",      1, 0, 1, 0, 32'hFFFF,     1, 0, 32'hFFFF,  0, 0);
        drive("rd_r0",      1, 0, 0, 0, 0,            0, 0, 0,         0, 7);
        drive("byp_r7",     1, 0, 1, 7, 32'h55,       0, 0, 0,         7, 7);
        drive("rd_r7",      1, 0, 0, 0, 0,            0, 0, 0,         7, 2);
        drive("pre_r2",     1, 0, 1, 2, 32'h1234,     1, 6, 32'h5678,  2, 6);
        drive("rst_wr",     1, 1, 1, 2, 32'h99,       1, 6, 32'h77,    2, 7);
        drive("rst_after",  1, 0, 0, 0, 0,            0, 0, 0,         2, 7);
        drive("same_val",   1, 0, 1, 7, 32'h0,        0, 0, 0,         7, 0);
        drive("same_chk",   1, 0, 0, 0, 0,            0, 0, 0,         7, 0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            wa  = $urandom_range(0, 1) == 1;
            wb  = $urandom_range(0, 1) == 1;
            ia  = $urandom_range(0, NREG - 1);
            ib  = ($urandom_range(0, 3) == 0) ? ia : $urandom_range(0, NREG - 1);
            ra  = ($urandom_range(0, 2) == 0) ? ia : $urandom_range(0, NREG - 1);
            rb  = ($urandom_range(0, 2) == 0) ? ib : $urandom_range(0, NREG - 1);
            da  = $urandom;
            db  = ($urandom_range(0, 7) == 0) ? mem[ib] : $urandom;
            drive("random", 1, rst, wa, ia, da, wb, ib, db, ra, rb);
        end
        drive("drain", 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);

        waits = 0;
        while (sb_q.size() > 0 && waits < 10) begin
            @(negedge clock);
            waits++;
        end
        #1;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
